// File: rtl/mul_arb_pkg.sv
// Shared widths, tag/operand types and the round-robin picker used by the
// multiplier-sharing arbiter and its result FIFOs.
package mul_arb_pkg;
   localparam int OP_W    = 8;
   localparam int P_W     = 16;
   localparam int MAX_REQ = 4;
   localparam int ID_W    = 2;

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic            sgn;
   } op_t;

   // One-hot pick of the first set bit at or after ptr, wrapping modulo n_req.
   function automatic logic [MAX_REQ-1:0] rr_pick(
      input logic [MAX_REQ-1:0] valid_mask,
      input logic [ID_W-1:0]    ptr,
      input int                 n_req
   );
      logic [MAX_REQ-1:0] grant;
      logic               found;
      int                 idx;
      grant = '0;
      found = 1'b0;
      for (int off = 0; off < MAX_REQ; off++) begin
         idx = (int'(ptr) + off) % n_req;
         if ((off < n_req) && !found && valid_mask[idx[ID_W-1:0]]) begin
            grant[idx[ID_W-1:0]] = 1'b1;
            found                = 1'b1;
         end
      end
      return grant;
   endfunction
endpackage

// File: rtl/mul_rsp_fifo.sv
// Per-requester result FIFO. Occupancy is bounded upstream by credits, so a
// push into a full FIFO indicates a credit bookkeeping bug.
module mul_rsp_fifo
   import mul_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         push_i,
   input  logic [P_W-1:0]               data_i,
   input  logic                         pop_i,
   output logic [P_W-1:0]               data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [P_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_i && !push_i) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign full    = (count_q == CNT_W'(DEPTH));
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(push_i && full));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(pop_i && (count_q == '0)));
endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front-end sharing one pipelined 8x8 multiplier among N_REQ
// requesters, with tag tracking through the core and per-requester result FIFOs.
module mul_share_arbiter
   import mul_arb_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int MUL_LAT = 1,
   parameter int MAX_OUT = 2
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n,
   input  logic                  enable,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [OP_W*N_REQ-1:0] req_a,
   input  logic [OP_W*N_REQ-1:0] req_b,
   input  logic [N_REQ-1:0]      req_signed,
   output logic [N_REQ-1:0]      rsp_valid,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic [P_W*N_REQ-1:0]  rsp_p,
   output logic [OP_W-1:0]       mul_a,
   output logic [OP_W-1:0]       mul_b,
   output logic                  mul_control,
   input  logic [P_W-1:0]        mul_p,
   output logic                  busy
);
   localparam int CR_W = $clog2(MAX_OUT + 1);
   localparam int NSTG = MUL_LAT + 1;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] pop;
   logic [N_REQ-1:0] push;
   logic [N_REQ-1:0] fifo_ne;
   logic             issue;
   logic [ID_W-1:0]  issue_id;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CR_W-1:0]  credit_q [N_REQ];
   logic [CR_W-1:0]  credit_d [N_REQ];
   op_t              op_q, op_d;
   tag_t             tag_q [NSTG];
   logic [NSTG-1:0]  tag_vld;
   logic [CR_W-1:0]  fifo_cnt  [N_REQ];
   logic [P_W-1:0]   fifo_data [N_REQ];

   // A requester may only issue while it holds a free FIFO slot.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = req_valid[i] && (credit_q[i] != '0) && enable;
      end
   end

   assign grant     = N_REQ'(rr_pick(MAX_REQ'(elig), rr_ptr_q, N_REQ));
   assign req_ready = grant;
   assign pop       = rsp_valid & rsp_ready;

   always_comb begin
      issue    = |grant;
      issue_id = '0;
      op_d     = op_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            issue_id = ID_W'(i);
            op_d     = '{a: req_a[i*OP_W +: OP_W], b: req_b[i*OP_W +: OP_W], sgn: req_signed[i]};
         end
      end
      rr_ptr_d = rr_ptr_q;
      if (issue) begin
         rr_ptr_d = (issue_id == ID_W'(N_REQ - 1)) ? '0 : issue_id + ID_W'(1);
      end
   end

   // Issue and pop in the same cycle cancel out.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         credit_d[i] = credit_q[i];
         case ({grant[i], pop[i]})
            2'b10:   credit_d[i] = credit_q[i] - CR_W'(1);
            2'b01:   credit_d[i] = credit_q[i] + CR_W'(1);
            default: credit_d[i] = credit_q[i];
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         rr_ptr_q <= '0;
         op_q     <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            credit_q[i] <= CR_W'(MAX_OUT);
         end
         for (int s = 0; s < NSTG; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         op_q     <= op_d;
         for (int i = 0; i < N_REQ; i++) begin
            credit_q[i] <= credit_d[i];
         end
         tag_q[0] <= '{vld: issue, id: issue_id};
         for (int s = 1; s < NSTG; s++) begin
            tag_q[s] <= tag_q[s-1];
         end
      end
   end

   assign mul_a       = op_q.a;
   assign mul_b       = op_q.b;
   assign mul_control = op_q.sgn;

   always_comb begin
      for (int s = 0; s < NSTG; s++) begin
         tag_vld[s] = tag_q[s].vld;
      end
   end

   // The last tag stage lines up with the core product for that operation.
   for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
      assign push[g] = tag_q[NSTG-1].vld && (tag_q[NSTG-1].id == ID_W'(g));

      mul_rsp_fifo #(
         .DEPTH (MAX_OUT)
      ) u_fifo (
         .clk_i   (wb_clk_i),
         .rst_n_i (wb_rst_n),
         .push_i  (push[g]),
         .data_i  (mul_p),
         .pop_i   (pop[g]),
         .data_o  (fifo_data[g]),
         .count_o (fifo_cnt[g])
      );

      assign fifo_ne[g]              = (fifo_cnt[g] != '0);
      assign rsp_p[g*P_W +: P_W]     = fifo_data[g];
   end

   assign rsp_valid = fifo_ne;
   assign busy      = (|tag_vld) || (|fifo_ne);

   a_grant_onehot: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n)
      $onehot0(grant));
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: a behavioural multiplier core plus a
// queue-based reference model of grants, credits and per-requester results.
module tb_mul_share_arbiter;
   localparam int N   = 2;
   localparam int LAT = 1;
   localparam int MO  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [8*N-1:0]  req_a;
   logic [8*N-1:0]  req_b;
   logic [N-1:0]  req_signed;
   logic [N-1:0]  rsp_valid;
   logic [N-1:0]  rsp_ready;
   logic [16*N-1:0] rsp_p;
   logic [7:0]    mul_a;
   logic [7:0]    mul_b;
   logic          mul_control;
   logic [15:0]   mul_p;
   logic          busy;

   int chk = 0;
   int err = 0;

   always #5 clk = ~clk;

   mul_share_arbiter #(.N_REQ(N), .MUL_LAT(LAT), .MAX_OUT(MO)) dut (
      .wb_clk_i    (clk),
      .wb_rst_n    (rst_n),
      .enable      (enable),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_signed  (req_signed),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_p       (rsp_p),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_control (mul_control),
      .mul_p       (mul_p),
      .busy        (busy)
   );

   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      if (s) begin
         if (ia > 127) ia = ia - 256;
         if (ib > 127) ib = ib - 256;
      end
      return 16'(ia * ib);
   endfunction

   // One-register multiplier core.
   logic [15:0] core_q = '0;
   always @(posedge clk) core_q <= ref_mul(mul_a, mul_b, mul_control);
   assign mul_p = core_q;

   // Reference model: each issued op is queued with the cycle its result becomes visible.
   typedef struct {
      logic [15:0] p;
      int          avail;
   } exp_t;

   exp_t         mq [N][$];
   int           m_credit [N];
   int           m_ptr;
   int           cyc = 0;
   logic [N-1:0] m_g;
   exp_t         m_e;

   function automatic logic [N-1:0] m_grant();
      logic [N-1:0] g;
      int           r;
      g = '0;
      for (int off = 0; off < N; off++) begin
         r = (m_ptr + off) % N;
         if ((g == '0) && req_valid[r] && (m_credit[r] > 0) && enable) g[r] = 1'b1;
      end
      return g;
   endfunction

   function automatic logic m_rsp_vld(input int r);
      return (mq[r].size() > 0) && (mq[r][0].avail <= cyc);
   endfunction

   function automatic logic [N-1:0] m_vld_vec();
      logic [N-1:0] v;
      for (int r = 0; r < N; r++) v[r] = m_rsp_vld(r);
      return v;
   endfunction

   function automatic logic m_busy();
      logic b;
      b = 1'b0;
      for (int r = 0; r < N; r++) if (mq[r].size() > 0) b = 1'b1;
      return b;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < N; r++) begin
            mq[r].delete();
            m_credit[r] = MO;
         end
         m_ptr = 0;
      end else begin
         m_g = m_grant();
         for (int r = 0; r < N; r++) begin
            if (m_rsp_vld(r) && rsp_ready[r]) begin
               void'(mq[r].pop_front());
               m_credit[r] = m_credit[r] + 1;
            end
         end
         cyc = cyc + 1;
         for (int r = 0; r < N; r++) begin
            if (m_g[r]) begin
               m_e.p     = ref_mul(req_a[r*8 +: 8], req_b[r*8 +: 8], req_signed[r]);
               m_e.avail = cyc + LAT + 1;
               mq[r].push_back(m_e);
               m_credit[r] = m_credit[r] - 1;
               m_ptr       = (r + 1) % N;
            end
         end
      end
   end

   task automatic set_op(input int r, input logic [7:0] a, input logic [7:0] b, input logic s);
      req_a[r*8 +: 8] = a;
      req_b[r*8 +: 8] = b;
      req_signed[r]   = s;
   endtask

   task automatic rand_ops();
      for (int r = 0; r < N; r++) set_op(r, 8'($urandom), 8'($urandom), 1'($urandom));
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      enable     = 1'b1;
      req_valid  = '0;
      rsp_ready  = '0;
      req_a      = '0;
      req_b      = '0;
      req_signed = '0;
      repeat (2) @(negedge clk);
      #1;
      chk++;
      if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
         err++;
         $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b, want 0/0/0", req_ready, rsp_valid, busy);
      end
      chk++;
      if (mul_a !== 8'd0 || mul_b !== 8'd0 || mul_control !== 1'b0) begin
         err++;
         $display("FAIL reset_mul: a=%h b=%h c=%b, want 00/00/0", mul_a, mul_b, mul_control);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      rsp_ready = '0;
      req_valid = 2'b01;
      set_op(0, 8'd12, 8'd11, 1'b0);
      #1;
      chk++;
      if (req_ready !== 2'b01) begin
         err++;
         $display("FAIL single_grant: got %b want 01", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      chk++;
      if (rsp_valid[0] !== 1'b0 || busy !== 1'b1) begin
         err++;
         $display("FAIL single_inflight: rsp_valid0=%b busy=%b, want 0/1", rsp_valid[0], busy);
      end
      @(negedge clk);
      #1;
      chk++;
      if (rsp_valid[0] !== 1'b0) begin
         err++;
         $display("FAIL single_early: rsp_valid0=%b want 0", rsp_valid[0]);
      end
      @(negedge clk);
      #1;
      chk++;
      if (rsp_valid[0] !== 1'b1) begin
         err++;
         $display("FAIL single_valid: rsp_valid0=%b want 1", rsp_valid[0]);
      end
      chk++;
      if (rsp_p[15:0] !== 16'd132) begin
         err++;
         $display("FAIL single_data: got %0d want 132", rsp_p[15:0]);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = '0;
      #1;
      chk++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
         err++;
         $display("FAIL single_pop: rsp_valid=%b busy=%b, want 00/0", rsp_valid, busy);
      end
   endtask

   task automatic test_signed();
      int          who  [3] = '{0, 1, 1};
      logic [7:0]  ta   [3] = '{8'hFE, 8'hFF, 8'hFF};
      logic [7:0]  tb   [3] = '{8'h03, 8'hFF, 8'hFF};
      logic        ts   [3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] tp   [3] = '{16'hFFFA, 16'hFE01, 16'h0001};
      int          r;
      logic        seen;
      for (int t = 0; t < 3; t++) begin
         r = who[t];
         @(negedge clk);
         rsp_ready    = '0;
         req_valid    = '0;
         req_valid[r] = 1'b1;
         set_op(r, ta[t], tb[t], ts[t]);
         @(negedge clk);
         req_valid = '0;
         seen      = 1'b0;
         for (int w = 0; w < 8 && !seen; w++) begin
            @(negedge clk);
            #1;
            seen = rsp_valid[r];
         end
         chk++;
         if (!seen) begin
            err++;
            $display("FAIL signed_timeout t=%0d: rsp_valid never rose", t);
         end
         chk++;
         if (rsp_p[r*16 +: 16] !== tp[t]) begin
            err++;
            $display("FAIL signed_data t=%0d: got %h want %h", t, rsp_p[r*16 +: 16], tp[t]);
         end
         rsp_ready[r] = 1'b1;
         @(negedge clk);
         rsp_ready = '0;
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] prev;
      int           n0;
      int           n1;
      n0        = 0;
      n1        = 0;
      prev      = '0;
      rsp_ready = 2'b11;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         req_valid = (c < 8) ? 2'b11 : 2'b00;
         rand_ops();
         #1;
         chk++;
         if (req_ready !== m_grant()) begin
            err++;
            $display("FAIL fair_ready c=%0d: got %b want %b", c, req_ready, m_grant());
         end
         chk++;
         if (rsp_valid !== m_vld_vec()) begin
            err++;
            $display("FAIL fair_rsp_valid c=%0d: got %b want %b", c, rsp_valid, m_vld_vec());
         end
         for (int r = 0; r < N; r++) begin
            if (m_rsp_vld(r)) begin
               chk++;
               if (rsp_p[r*16 +: 16] !== mq[r][0].p) begin
                  err++;
                  $display("FAIL fair_data c=%0d r=%0d: got %h want %h", c, r, rsp_p[r*16 +: 16], mq[r][0].p);
               end
            end
         end
         if (c < 8) begin
            chk++;
            if (req_ready === prev || req_ready === '0) begin
               err++;
               $display("FAIL fair_alternate c=%0d: got %b previous %b", c, req_ready, prev);
            end
            prev = req_ready;
            n0   = n0 + int'(req_ready[0]);
            n1   = n1 + int'(req_ready[1]);
         end
      end
      chk++;
      if (n0 != 4 || n1 != 4) begin
         err++;
         $display("FAIL fair_count: got %0d/%0d want 4/4", n0, n1);
      end
      chk++;
      if (busy !== 1'b0) begin
         err++;
         $display("FAIL fair_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_backpressure();
      int n1;
      n1        = 0;
      rsp_ready = 2'b01;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         req_valid = 2'b11;
         rand_ops();
         #1;
         chk++;
         if (req_ready !== m_grant()) begin
            err++;
            $display("FAIL bp_ready c=%0d: got %b want %b", c, req_ready, m_grant());
         end
         for (int r = 0; r < N; r++) begin
            if (m_rsp_vld(r) && r == 0) begin
               chk++;
               if (rsp_p[15:0] !== mq[0][0].p) begin
                  err++;
                  $display("FAIL bp_data0 c=%0d: got %h want %h", c, rsp_p[15:0], mq[0][0].p);
               end
            end
         end
         n1 = n1 + int'(req_ready[1]);
      end
      chk++;
      if (n1 != MO || req_ready[1] !== 1'b0) begin
         err++;
         $display("FAIL bp_stall: req1 issues %0d ready1=%b, want %0d/0", n1, req_ready[1], MO);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         rsp_ready = 2'b11;
         req_valid = (c < 4) ? 2'b10 : 2'b00;
         rand_ops();
         #1;
         chk++;
         if (req_ready !== m_grant() || rsp_valid !== m_vld_vec()) begin
            err++;
            $display("FAIL bp_resume c=%0d: ready=%b rsp_valid=%b want %b/%b", c, req_ready, rsp_valid, m_grant(), m_vld_vec());
         end
         for (int r = 0; r < N; r++) begin
            if (m_rsp_vld(r)) begin
               chk++;
               if (rsp_p[r*16 +: 16] !== mq[r][0].p) begin
                  err++;
                  $display("FAIL bp_data c=%0d r=%0d: got %h want %h", c, r, rsp_p[r*16 +: 16], mq[r][0].p);
               end
            end
         end
         if (c < 2) begin
            chk++;
            if (req_ready[1] !== ((c == 1) ? 1'b1 : 1'b0)) begin
               err++;
               $display("FAIL bp_regrant c=%0d: ready1=%b want %b", c, req_ready[1], (c == 1));
            end
         end
      end
   endtask

   task automatic test_pop_issue();
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         req_valid = (c < 40) ? 2'b01 : 2'b00;
         rsp_ready = (c < 40) ? {1'b1, 1'($urandom)} : 2'b11;
         rand_ops();
         #1;
         chk++;
         if (req_ready !== m_grant()) begin
            err++;
            $display("FAIL popiss_ready c=%0d: got %b want %b", c, req_ready, m_grant());
         end
         chk++;
         if (rsp_valid !== m_vld_vec() || busy !== m_busy()) begin
            err++;
            $display("FAIL popiss_rsp c=%0d: rsp_valid=%b busy=%b want %b/%b", c, rsp_valid, busy, m_vld_vec(), m_busy());
         end
         if (m_rsp_vld(0)) begin
            chk++;
            if (rsp_p[15:0] !== mq[0][0].p) begin
               err++;
               $display("FAIL popiss_data c=%0d: got %h want %h", c, rsp_p[15:0], mq[0][0].p);
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      int n0;
      @(negedge clk);
      rsp_ready = '0;
      req_valid = 2'b01;
      rand_ops();
      @(negedge clk);
      req_valid = 2'b10;
      @(negedge clk);
      req_valid = '0;
      #1;
      chk++;
      if (busy !== 1'b1) begin
         err++;
         $display("FAIL rstmid_pre: busy=%b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      chk++;
      if (rsp_valid !== '0 || busy !== 1'b0 || req_ready !== '0) begin
         err++;
         $display("FAIL rstmid_assert: rsp_valid=%b busy=%b ready=%b want 00/0/00", rsp_valid, busy, req_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         chk++;
         if (rsp_valid !== '0 || busy !== 1'b0) begin
            err++;
            $display("FAIL rstmid_stale c=%0d: rsp_valid=%b busy=%b want 00/0", c, rsp_valid, busy);
         end
      end
      n0 = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid = 2'b01;
         #1;
         n0 = n0 + int'(req_ready[0]);
      end
      @(negedge clk);
      req_valid = '0;
      chk++;
      if (n0 != MO) begin
         err++;
         $display("FAIL rstmid_credits: issues %0d want %0d", n0, MO);
      end
      rsp_ready = 2'b11;
      repeat (8) @(negedge clk);
      #1;
      chk++;
      if (busy !== 1'b0 || m_busy() !== 1'b0) begin
         err++;
         $display("FAIL rstmid_drain: busy=%b want 0", busy);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 320; c++) begin
         @(negedge clk);
         if (c < 300) begin
            enable    = ($urandom_range(0, 3) != 0);
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
         end else begin
            enable    = 1'b1;
            req_valid = '0;
            rsp_ready = '1;
         end
         rand_ops();
         #1;
         chk++;
         if (req_ready !== m_grant()) begin
            err++;
            $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, m_grant());
         end
         chk++;
         if (rsp_valid !== m_vld_vec() || busy !== m_busy()) begin
            err++;
            $display("FAIL rand_rsp c=%0d: rsp_valid=%b busy=%b want %b/%b", c, rsp_valid, busy, m_vld_vec(), m_busy());
         end
         for (int r = 0; r < N; r++) begin
            if (m_rsp_vld(r)) begin
               chk++;
               if (rsp_p[r*16 +: 16] !== mq[r][0].p) begin
                  err++;
                  $display("FAIL rand_data c=%0d r=%0d: got %h want %h", c, r, rsp_p[r*16 +: 16], mq[r][0].p);
               end
            end
         end
      end
      chk++;
      if (busy !== 1'b0) begin
         err++;
         $display("FAIL rand_idle: busy=%b want 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_signed();
      test_fairness();
      test_backpressure();
      test_pop_issue();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end
endmodule
